// File: rtl/ram32x4_arbiter_pkg.sv
// Shared types and defaults for the ram32x4 round-robin arbiter.
// Widths of ram_cmd_t follow the package defaults, which the top uses as its parameter defaults.
package ram32x4_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int MAX_REQ    = 4;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } ram_cmd_t;

  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
  } rtag_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram32x4_arbiter_if.sv
// Requester-side bus of the arbiter: req/ack handshake plus tagged read return.
interface ram32x4_arbiter_if
  import ram32x4_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      init_busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  ack, rvalid, rdata, init_busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output ack, rvalid, rdata, init_busy
  );

endinterface

// File: rtl/ram32x4_arbiter_rr_arbiter.sv
// Round-robin picker: combinational one-hot grant searching upward from a registered pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_winner;
  logic             w_found;

  always_comb begin
    int idx;
    idx      = 0;
    o_grant  = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && i_enable && i_req[idx]) begin
        w_found      = 1'b1;
        o_grant[idx] = 1'b1;
        w_winner     = PTR_W'(idx);
      end
    end
  end

  // The pointer only moves on a transfer, landing just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_found)
      r_ptr <= (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
  end

endmodule

// File: rtl/ram32x4_arbiter.sv
// Shares one registered-input 32x4 RAM between NUM_REQ requesters with round-robin arbitration.
// Optional RAM clear after reset: define RAM32X4_ARB_INIT_CLEAR_EN.
module ram32x4_arbiter
  import ram32x4_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  ram32x4_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic               w_initBusy;
  logic               w_arbEn;
  logic [ADDR_W-1:0]  w_clrAddr;
  ram_cmd_t           w_cmd;

  logic [ADDR_W-1:0]  r_ramAddr;
  logic [DATA_W-1:0]  r_ramData;
  logic               r_ramWren;
  rtag_t              r_tagPipe [RD_LAT+1];
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata;

`ifdef RAM32X4_ARB_INIT_CLEAR_EN
  clr_state_t        r_state;
  clr_state_t        w_nextState;
  logic [ADDR_W-1:0] r_clrCnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= CLEAR;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == CLEAR && (&r_clrCnt)) w_nextState = RUN;
  end

  always_comb begin
    w_initBusy = (r_state == CLEAR);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)        r_clrCnt <= '0;
    else if (w_initBusy) r_clrCnt <= r_clrCnt + ADDR_W'(1);
  end

  assign w_clrAddr = r_clrCnt;
`else
  assign w_initBusy = 1'b0;
  assign w_clrAddr  = '0;
`endif

  assign w_arbEn = ~w_initBusy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .i_req    (bus.req),
    .i_enable (w_arbEn),
    .o_grant  (w_grant)
  );

  assign w_xfer = |(bus.req & w_grant);

  always_comb begin
    w_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_cmd.we    = bus.req_we[i];
        w_cmd.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_cmd.wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clear writes own the RAM port while busy; otherwise the winner is issued for one cycle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ramAddr <= '0;
      r_ramData <= '0;
      r_ramWren <= 1'b0;
    end else if (w_initBusy) begin
      r_ramAddr <= w_clrAddr;
      r_ramData <= '0;
      r_ramWren <= 1'b1;
    end else if (w_xfer) begin
      r_ramAddr <= w_cmd.addr;
      r_ramData <= w_cmd.wdata;
      r_ramWren <= w_cmd.we;
    end else begin
      r_ramWren <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= RD_LAT; i++) r_tagPipe[i] <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_tagPipe[0] <= rtag_t'{valid: w_xfer & ~w_cmd.we, id: MAX_REQ'(w_grant)};
      for (int i = 1; i <= RD_LAT; i++) r_tagPipe[i] <= r_tagPipe[i-1];
      if (r_tagPipe[RD_LAT].valid) begin
        r_rvalid <= NUM_REQ'(r_tagPipe[RD_LAT].id);
        r_rdata  <= ram_q;
      end else begin
        r_rvalid <= '0;
      end
    end
  end

  assign bus.ack       = w_grant;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.init_busy = w_initBusy;
  assign ram_address   = r_ramAddr;
  assign ram_data      = r_ramData;
  assign ram_wren      = r_ramWren;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Self-checking bench for ram32x4_arbiter: per-requester command queues drive the bus,
// a grant-order memory model predicts acks, RAM issue and tagged read returns.
module tb_ram32x4_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 5;
  localparam int DW      = 4;
  localparam int RDLAT   = 1;
  localparam int RET_LAT = RDLAT + 2;
`ifdef RAM32X4_ARB_INIT_CLEAR_EN
  localparam int CLR_CYCLES = 32;
`else
  localparam int CLR_CYCLES = 0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  ram32x4_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram32x4_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDLAT)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // RAM with registered address/data/wren and q one clock later
  logic [DW-1:0] ramMem [32];
  logic [AW-1:0] ramAddrQ;
  always @(posedge CLOCK_50) begin
    ramAddrQ <= ram_address;
    if (ram_wren) ramMem[ram_address] <= ram_data;
  end
  assign ram_q = ramMem[ramAddrQ];

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {int due; int id; logic [DW-1:0] data;} ret_t;

  cmd_t          cmdQ [NREQ][$];
  ret_t          retQ [$];
  logic [DW-1:0] refMem [32];
  int            refPtr, busyLeft, cyc;
  logic          pendValid, pendWe;
  logic [AW-1:0] pendAddr;
  logic [DW-1:0] pendData;
  int            testsRun, testsFailed;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pushCmd(input int id, input int we, input int addr, input int data);
    cmd_t c;
    c.we   = (we != 0);
    c.addr = AW'(addr);
    c.data = DW'(data);
    cmdQ[id].push_back(c);
  endtask

  task automatic checkRegistered();
    logic [31:0]   expRv;
    logic [DW-1:0] expRd;
    expRv = '0;
    expRd = '0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      expRv = 32'(1) << retQ[0].id;
      expRd = retQ[0].data;
      void'(retQ.pop_front());
    end
    checkOutput("rvalid", 32'(bus.rvalid), expRv);
    if (expRv != 0) checkOutput("rdata", 32'(bus.rdata), 32'(expRd));
    checkOutput("ram_wren", 32'(ram_wren), 32'(pendValid & pendWe));
    if (pendValid) begin
      checkOutput("ram_address", 32'(ram_address), 32'(pendAddr));
      checkOutput("ram_data", 32'(ram_data), 32'(pendData));
    end
  endtask

  task automatic applyStimulus();
    int          w;
    logic [31:0] expAck;
    for (int i = 0; i < NREQ; i++) begin
      if (cmdQ[i].size() > 0) begin
        bus.req[i]                = 1'b1;
        bus.req_we[i]             = cmdQ[i][0].we;
        bus.req_addr[i*AW +: AW]  = cmdQ[i][0].addr;
        bus.req_wdata[i*DW +: DW] = cmdQ[i][0].data;
      end else begin
        bus.req[i]                = 1'b0;
        bus.req_we[i]             = 1'($urandom_range(0, 1));
        bus.req_addr[i*AW +: AW]  = AW'($urandom);
        bus.req_wdata[i*DW +: DW] = DW'($urandom);
      end
    end
    #1;
    checkOutput("init_busy", 32'(bus.init_busy), 32'(busyLeft > 0));
    w = -1;
    if (busyLeft == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (refPtr + k) % NREQ;
        if (w < 0 && cmdQ[idx].size() > 0) w = idx;
      end
    end
    expAck = (w >= 0) ? (32'(1) << w) : 32'(0);
    checkOutput("ack", 32'(bus.ack), expAck);
    if (busyLeft > 0) begin
      pendValid = 1'b1;
      pendWe    = 1'b1;
      pendAddr  = AW'(CLR_CYCLES - busyLeft);
      pendData  = '0;
      busyLeft--;
    end else if (w >= 0) begin
      cmd_t c;
      c         = cmdQ[w].pop_front();
      pendValid = 1'b1;
      pendWe    = c.we;
      pendAddr  = c.addr;
      pendData  = c.data;
      if (c.we) refMem[c.addr] = c.data;
      else      retQ.push_back('{cyc + RET_LAT, w, refMem[c.addr]});
      refPtr = (w + 1) % NREQ;
    end else begin
      pendValid = 1'b0;
    end
  endtask

  task automatic stepCycle();
    @(negedge CLOCK_50);
    cyc++;
    checkRegistered();
    applyStimulus();
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ack", 32'(bus.ack), 0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 0);
    checkOutput("rst_rdata", 32'(bus.rdata), 0);
    checkOutput("rst_ram_wren", 32'(ram_wren), 0);
    checkOutput("rst_ram_address", 32'(ram_address), 0);
    checkOutput("rst_ram_data", 32'(ram_data), 0);
    checkOutput("rst_init_busy", 32'(bus.init_busy), 32'(CLR_CYCLES > 0));
  endtask

  task automatic doReset(input int holdCycles);
    @(negedge CLOCK_50);
    cyc++;
    checkRegistered();
    reset_n = 1'b0;
    bus.req = '0;
    #1;
    checkResetValues();
    repeat (holdCycles) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    checkResetValues();
    retQ.delete();
    for (int i = 0; i < NREQ; i++) cmdQ[i].delete();
    refPtr    = 0;
    pendValid = 1'b0;
    busyLeft  = CLR_CYCLES;
    if (CLR_CYCLES > 0) for (int a = 0; a < 32; a++) refMem[a] = '0;
    reset_n = 1'b1;
    applyStimulus();
  endtask

  function automatic bit modelBusy();
    bit b;
    b = pendValid || (retQ.size() > 0) || (busyLeft > 0);
    for (int i = 0; i < NREQ; i++) if (cmdQ[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while (modelBusy() && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    int n;
    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    refPtr      = 0;
    busyLeft    = 0;
    pendValid   = 1'b0;
    pendWe      = 1'b0;
    pendAddr    = '0;
    pendData    = '0;
    ramAddrQ    = '0;
    for (int a = 0; a < 32; a++) begin
      ramMem[a] = '0;
      refMem[a] = '0;
    end
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    doReset(3);
    // a request raised right away must wait out any clear sequence
    pushCmd(0, 0, 9, 0);
    runUntilIdle(100);

    pushCmd(0, 1, 5, 'hA);
    pushCmd(0, 0, 5, 0);
    runUntilIdle(50);

    pushCmd(0, 1, 3, 3);
    pushCmd(1, 1, 7, 7);
    runUntilIdle(50);
    for (int k = 0; k < 6; k++) begin
      pushCmd(0, 0, 3, 0);
      pushCmd(1, 0, 7, 0);
    end
    runUntilIdle(100);

    for (int a = 0; a < 32; a++) pushCmd(a % 2, 1, a, int'($urandom_range(0, 15)));
    runUntilIdle(100);
    for (int a = 0; a < 32; a++) pushCmd(1, 0, a, 0);
    runUntilIdle(100);

    pushCmd(1, 1, 31, 'hF);
    pushCmd(1, 0, 31, 0);
    runUntilIdle(50);

    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cmdQ[i].size() == 0 && $urandom_range(0, 9) < 6)
          pushCmd(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end
      stepCycle();
    end
    runUntilIdle(100);

    // reset lands one cycle after a read is acked; its data must never return
    pushCmd(0, 0, 5, 0);
    n = 0;
    while (cmdQ[0].size() > 0 && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("read_acked_before_reset", 32'(n < 20), 1);
    doReset(2);

    pushCmd(0, 0, 5, 0);
    pushCmd(1, 0, 31, 0);
    runUntilIdle(100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ram32x4_arbiter.md
Name: ram32x4_arbiter

Overview:
- Shares one 32x4 single-port RAM (registered address/data/wren, 1-cycle q) between NUM_REQ requesters with round-robin arbitration.
- Each requester issues reads or writes with a req/ack handshake and gets read data back on a tagged, fixed-latency return channel.
- Sits between DE1_SoC-level requesters (switch UI, scanner, etc.) and the ram32x4 instance; drives all RAM ports.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ADDR_W, 5: RAM address width.
- DATA_W, 4: RAM data width.
- RD_LAT, 1: RAM clock cycles from address register to valid q.

Ports:
- CLOCK_50  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held with its fields until acked.
- req_we  input  NUM_REQ  1=write, 0=read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data.
- ack  output  NUM_REQ  one-hot-or-zero; transfer occurs on a rising edge with req[i]&ack[i].
- rvalid  output  NUM_REQ  one-hot-or-zero; read data valid for requester i.
- rdata  output  DATA_W  read data; meaningful only when rvalid is nonzero.
- init_busy  output  1  high while the RAM clear sequence runs; always 0 when the feature is compiled out.
- ram_address  output  ADDR_W  to RAM address.
- ram_data  output  DATA_W  to RAM data.
- ram_wren  output  1  to RAM wren.
- ram_q  input  DATA_W  from RAM q.

Behaviour:
- Reset (async assert, sync release) sets: ack=0, rvalid=0, rdata=0, ram_address=0, ram_data=0, ram_wren=0, RR pointer=0, return pipeline flushed.
- Arbitration:
  - ack is combinational from req, RR pointer, and init_busy.
  - The winner is the first requester with req high, searching from pointer upward with wrap (NUM_REQ-1 wraps to 0).
  - At most one ack per cycle; ack=0 while init_busy.
  - After each transfer, pointer = winner+1 mod NUM_REQ. With no transfer, pointer holds.
- Issue: on the transfer edge, the winner's addr/wdata/we are registered onto ram_address/ram_data/ram_wren for exactly one cycle.
  - ram_wren=0 in any cycle with no transfer.
  - ram_address/ram_data hold their last value when idle.
- Throughput: one access per cycle, back-to-back. A requester holding req after its ack competes again normally.
- Read return:
  - The tag (one-hot winner, read flag) goes through a shift pipeline of depth RD_LAT+1.
  - rdata registers ram_q; rvalid[i] asserts for exactly 1 cycle.
  - Latency from transfer edge to rvalid-high cycle: RD_LAT+2 cycles (3 by default).
  - Writes produce no rvalid.
- Ordering: accesses complete in grant order. A read granted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and the pointer returns to 0.
- Arithmetic:
  - Pointer width is $clog2(NUM_REQ), with explicit wrap.
  - Packed-field slices use parameterised widths; no truncation warnings.

Optional Feature:
- Macro: RAM32X4_ARB_INIT_CLEAR_EN.
- Defined:
  - After reset release, an internal counter writes DATA_W'0 to addresses 0..2^ADDR_W-1 over 2^ADDR_W consecutive cycles (ram_wren=1, ascending ram_address).
  - init_busy is 1 from reset through the cycle of the last write; all ack are forced 0 during this time.
  - Reset during clear restarts the sequence from address 0.
- Undefined: no clear sequence; init_busy is tied 0; requests are accepted from the first cycle after reset release.

Decomposition:
- Package ram32x4_arb_pkg:
  - Defaults ADDR_W=5, DATA_W=4, MAX_REQ=4.
  - typedef ram_cmd_t struct {we, addr, wdata}.
  - typedef rtag_t struct {valid, onehot id}.
- Sub-module rr_arbiter: combinational round-robin picker plus registered pointer; inputs req, enable; outputs one-hot grant.
- The top does issue registers, return pipeline, and optional clear FSM (states CLEAR, RUN).

Test Plan:
- Single write then read: req0 writes addr 5 data 0xA, then reads addr 5 -> ram_wren pulse with ram_address=5, ram_data=0xA; rvalid[0] 3 cycles after read ack with rdata=0xA.
- Contention: req0 and req1 held high from the cycle after reset, reading addrs 3 and 7 (preloaded 0x3, 0x7) -> acks alternate 0,1,0,1; rvalid alternates with rdata 0x3, 0x7; no requester starves.
- Back-to-back: requester 1 alone issues reads of addrs 0..31 on consecutive cycles -> 32 acks, 32 consecutive rvalid[1] cycles in address order, no gaps.
- Wrap/same-address: write 0xF to addr 31, then immediately read addr 31 -> rdata=0xF; pointer wraps from 1 to 0 correctly.
- Reset mid-read: assert reset_n=0 one cycle after a read ack -> no rvalid afterwards; all outputs at reset values; next grant goes to requester 0.
- With RAM32X4_ARB_INIT_CLEAR_EN: after reset, init_busy high for 32 cycles with addresses 0..31 written with 0; a req during clear is not acked; a read of any address after clear returns 0x0.
